alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Multi-cycle arithmetic unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage. The core stalls on InReady/OutValid.
- Iterative datapath: multiply is shift-add, divide is restoring. One bit per clock.
- Width-parametrised, with valid/ready handshakes on both the issue side and the result side.

Parameters:
DATA_WIDTH, 32, operand and result width; must be an even number ≥ 8
OPCODE_LENGTH, 3, Operation width; encoding equals RV32M funct3

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
InValid  input  1  operation request
InReady  output  1  unit can accept a request
Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  DATA_WIDTH  rs1 value (multiplicand / dividend)
SrcB  input  DATA_WIDTH  rs2 value (multiplier / divisor)
Flush  input  1  abort the in-flight operation (pipeline kill)
OutValid  output  1  ALUResult is valid
OutReady  input  1  consumer takes the result
ALUResult  output  DATA_WIDTH  result

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - InReady=1, OutValid=0, ALUResult=0.
  - Iteration counter and internal registers are cleared.
- InReady = (state==IDLE). It is a pure function of state, so there is no combinational path from InValid.
- Accept condition: InValid && InReady && !Flush on a rising edge.
  - Latch Operation and the operand magnitudes (absolute values for the signed operands of the selected op).
  - Record the result sign.
  - Load counter = DATA_WIDTH-1.
  - Go to CALC.
- CALC: one iteration per edge. The counter decrements. On the edge where counter==0, go to FIX.
- Multiply:
  - 2*DATA_WIDTH-bit product register.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - MULHSU: SrcA signed, SrcB unsigned.
- Divide:
  - Restoring division on magnitudes.
  - DIV/REM are signed and DIVU/REMU unsigned.
  - The quotient is truncated toward zero. The remainder takes the sign of the dividend.
- FIX (one cycle):
  - Apply two's-complement negation if required.
  - Register ALUResult, go to DONE.
- DONE:
  - OutValid=1 and ALUResult is held stable.
  - On OutReady, return to IDLE; OutValid drops on that edge.
- Latency: OutValid first high DATA_WIDTH+2 edges after the accept edge (34 for DATA_WIDTH=32). Minimum issue interval is DATA_WIDTH+3 cycles; back-to-back accept from DONE is not supported.
- Special cases (results as the RISC-V spec defines):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV gives SrcA; REM gives 0.
  - Without the optional feature, these still take the full latency.
- Flush:
  - In CALC, FIX or DONE: return to IDLE on the next edge; OutValid=0; the result is discarded.
  - Flush while IDLE with InValid high: the request is not accepted.
  - Flush has priority over OutReady.
- Reset mid-operation: immediate IDLE. No stale OutValid after rst_n deasserts.
- Operation, SrcA and SrcB are ignored outside the accept edge.

Optional Feature:
- Macro: ALU_MULDIV_EARLY_OUT_EN.
- Defined:
  - Divisor-zero, signed-overflow, and multiply with either operand 0 skip CALC and FIX.
  - The result is computed on the accept edge and the unit goes directly to DONE.
  - OutValid is high 1 edge after accept.
- Not defined:
  - All operations use the fixed DATA_WIDTH+2 latency.
  - Results are identical either way.

Test Plan:
- MULH, SrcA=0x80000000, SrcB=0x80000000 -> ALUResult=0x40000000 exactly 34 edges after accept; MUL on the same operands -> 0x00000000.
- MULHSU, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> 0xFFFFFFFF; MULHU on the same operands -> 0xFFFFFFFE.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0x64/0x7 -> 0x0000000E, REMU -> 0x00000002.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. With ALU_MULDIV_EARLY_OUT_EN, each of these has OutValid 1 edge after accept.
- Backpressure and handshake:
  - Hold OutReady=0 for 10 cycles after OutValid: ALUResult stays stable and InReady=0.
  - Assert OutReady: IDLE on the next edge, InReady=1.
- Flush and reset mid-operation:
  - Flush at CALC cycle 10: IDLE next edge and OutValid never rises; a subsequent MUL 3*4 returns 0x0000000C.
  - rst_n pulsed low mid-CALC: outputs reset immediately.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Optional ALU_MULDIV_EARLY_OUT_EN: trivial cases (divide by zero, signed overflow, zero multiply) finish on the accept edge.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]    op_q;
  logic          neg_q, spec_q;
  logic [W-1:0]  spec_res_q, dvs_q, res_q;
  logic [2*W-1:0] prod_q;
  logic [CW-1:0] cnt_q;

  // issue-side decode, only meaningful on the accept edge
  logic [2:0]   op;
  logic         is_div, a_sgn, b_sgn, a_neg, b_neg, a_zero, b_zero, ovf, special, neg_res, accept;
  logic [W-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    op      = Operation[2:0];
    is_div  = op[2];
    a_sgn   = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    b_sgn   = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    a_neg   = a_sgn & SrcA[W-1];
    b_neg   = b_sgn & SrcB[W-1];
    a_mag   = a_neg ? -SrcA : SrcA;
    b_mag   = b_neg ? -SrcB : SrcB;
    a_zero  = (SrcA == '0);
    b_zero  = (SrcB == '0);
    ovf     = is_div & ~op[0] & (SrcA == {1'b1, {(W-1){1'b0}}}) & (SrcB == '1);
    special = is_div ? (b_zero | ovf) : (a_zero | b_zero);
    // remainder follows the dividend; quotient and product follow the sign product
    neg_res = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
    spec_res = '0;
    if (is_div) begin
      if (b_zero) spec_res = op[1] ? SrcA : '1;
      else        spec_res = op[1] ? '0 : SrcA;
    end
    accept = (state == IDLE) & InValid & ~Flush;
  end

  // one iteration of either datapath
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] prod_nx, full;
  logic [W-1:0]   fix_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? dvs_q : '0)};
    div_trial = prod_q[2*W-1:W-1] - {1'b0, dvs_q};
    if (!op_q[2])        prod_nx = {mul_sum, prod_q[W-1:1]};
    else if (!div_trial[W]) prod_nx = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
    else                 prod_nx = {prod_q[2*W-2:0], 1'b0};
    full = neg_q ? -prod_q : prod_q;
    case (op_q)
      3'b000:         fix_res = full[W-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = full[2*W-1:W];
      3'b100, 3'b101: fix_res = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
      default:        fix_res = neg_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (EARLY && special) ? DONE : CALC;
      CALC: if (Flush) state_nx = IDLE;
            else if (cnt_q == '0) state_nx = FIX;
      FIX:  state_nx = Flush ? IDLE : DONE;
      DONE: if (Flush || OutReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      dvs_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
    end else begin
      if (accept) begin
        op_q       <= op;
        neg_q      <= neg_res;
        spec_q     <= special;
        spec_res_q <= spec_res;
        dvs_q      <= is_div ? b_mag : a_mag;
        prod_q     <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
        cnt_q      <= CW'(W-1);
        if (EARLY && special) res_q <= spec_res;
      end else if (state == CALC) begin
        prod_q <= prod_nx;
        cnt_q  <= cnt_q - CW'(1);
      end else if (state == FIX && !Flush) begin
        res_q <= spec_q ? spec_res_q : fix_res;
      end
    end
  end

  assign ALUResult = res_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed + random bench for alu_muldiv; scoreboard queue holds expected results in issue order.
module tb_alu_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        InValid = 1'b0, InReady, Flush = 1'b0, OutValid, OutReady = 1'b0;
  logic [2:0]  Operation = '0;
  logic [31:0] SrcA = '0, SrcB = '0, ALUResult;

  int errors = 0, checks = 0;
  logic [31:0] sb[$];

`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .ALUResult(ALUResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, zb, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a}; sb64 = {{32{b[31]}}, b}; zb = {32'b0, b};
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sb64; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Issue one op, wait for the result (edges counted including the accept edge), pop and compare.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit hold);
    int n, lat;
    @(negedge clk);
    InValid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    sb.push_back(exp);
    lat = (EARLY && is_special(op, a, b)) ? 1 : 34;
    @(posedge clk); #1;
    InValid = 1'b0; SrcA = 32'hDEADBEEF; SrcB = 32'h0BADF00D; Operation = 3'd7;
    n = 1;
    @(negedge clk);
    while (!OutValid && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, lat);
    chk(tag, ALUResult, sb.pop_front());
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk({tag, "_hold_res"}, ALUResult, exp);
        chk({tag, "_hold_inready"}, InReady, 1'b0);
      end
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    @(negedge clk);
    chk({tag, "_ret_inready"}, InReady, 1'b1);
    chk({tag, "_ret_outvalid"}, OutValid, 1'b0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit seen;

    #23;
    chk("rst_inready", InReady, 1'b1);
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_result", ALUResult, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    issue("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    issue("mul_min",  3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    issue("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    issue("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    issue("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
    issue("divu_100_7", 3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0);
    issue("remu_100_7", 3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0);
    issue("divu_by0", 3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    issue("rem_by0",  3'd6, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0);
    issue("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    issue("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    issue("mul_hold", 3'd0, 32'h00001234, 32'h00000100, 32'h00123400, 1'b1);

    // flush while idle blocks the accept
    @(negedge clk); InValid = 1'b1; Flush = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1; InValid = 1'b0; Flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_inready", InReady, 1'b1);

    // flush at CALC cycle 10
    @(negedge clk); InValid = 1'b1; Operation = 3'd1; SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0;
    @(posedge clk); #1; InValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); Flush = 1'b1;
    @(posedge clk); #1; Flush = 1'b0;
    @(negedge clk);
    chk("flush_inready", InReady, 1'b1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (OutValid) seen = 1'b1; end
    chk("flush_no_outvalid", seen, 1'b0);
    issue("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'h0000000C, 1'b0);

    // reset pulsed mid-CALC
    @(negedge clk); InValid = 1'b1; Operation = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1; InValid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    chk("midrst_inready", InReady, 1'b1);
    chk("midrst_outvalid", OutValid, 1'b0);
    chk("midrst_result", ALUResult, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (OutValid) seen = 1'b1; end
    chk("midrst_no_outvalid", seen, 1'b0);

    for (int k = 0; k < 16; k++) begin
      rop = 3'(k % 8);
      ra = $urandom; rb = $urandom;
      if (k == 9) rb = 32'h0;
      if (k == 10) ra = 32'h0;
      issue($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
